// File: rtl/attack_controller_if.sv
// Player-facing I/O bundle of the battleship attack controller:
// switches and buttons in, LED matrix drive and game results out.
interface attack_controller_if;
   logic       onOff;
   logic       status;
   logic       save_game;
   logic       attack_button;
   logic [6:0] col1_in;
   logic [6:0] col2_in;
   logic [6:0] col3_in;
   logic [6:0] col4_in;
   logic [6:0] col5_in;
   logic [2:0] columns_attack;
   logic [2:0] rows_attack;
   logic [6:0] col1_out;
   logic [6:0] col2_out;
   logic [6:0] col3_out;
   logic [6:0] col4_out;
   logic [6:0] col5_out;
   logic       hit;
   logic       miss;
   logic       repeat_shot;
   logic       invalid_shot;
   logic       win;
   logic       game_over;
   logic [4:0] shots_left;
   // Handshake: save_game/attack_button are levels with no ready; each rising level is one
   // request, and hit/miss/repeat_shot/invalid_shot are one-cycle results that cannot be stalled.
   // fsm_state encoding: 0 OFF, 1 PLACE, 2 ARMED, 3 ATTACK, 4 WIN, 5 LOSE.
   logic [2:0] fsm_state;

   modport master (
      output onOff, status, save_game, attack_button,
      output col1_in, col2_in, col3_in, col4_in, col5_in,
      output columns_attack, rows_attack,
      input  col1_out, col2_out, col3_out, col4_out, col5_out,
      input  hit, miss, repeat_shot, invalid_shot, win, game_over, shots_left, fsm_state
   );

   modport slave (
      input  onOff, status, save_game, attack_button,
      input  col1_in, col2_in, col3_in, col4_in, col5_in,
      input  columns_attack, rows_attack,
      output col1_out, col2_out, col3_out, col4_out, col5_out,
      output hit, miss, repeat_shot, invalid_shot, win, game_over, shots_left, fsm_state
   );
endinterface

// File: rtl/attack_controller.sv
// Battleship game sequencer: placement, fleet latch, shot processing, win/loss detection
// and ownership of the 5x7 LED matrix column drive.
module attack_controller #(
   parameter int MAX_SHOTS = 15,
   parameter int BLINK_DIV = 25000000
) (
   input logic                clk,
   input logic                reset,
   attack_controller_if.slave bus
);
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic [2:0] {
      OFF    = 3'd0,
      PLACE  = 3'd1,
      ARMED  = 3'd2,
      ATTACK = 3'd3,
      WIN    = 3'd4,
      LOSE   = 3'd5
   } state_t;

   state_t state;
   state_t next_state;

   logic [1:0] save_sync;
   logic [1:0] atk_sync;
   logic       save_prev;
   logic       atk_prev;
   logic       save_rise;
   logic       atk_rise;

   // Boards are flattened with cell (column c, row r) at bit c*7+r.
   logic [34:0] col_in_flat;
   logic [34:0] place_q;
   logic [34:0] board;
   logic [34:0] shot_map;
   logic [34:0] display;
   logic [34:0] target_mask;
   logic [5:0]  target_idx;
   logic        target_invalid;
   logic        already_shot;
   logic        is_ship;

   logic [5:0]  in_cells;
   logic [5:0]  ship_cells;
   logic [5:0]  hits;
   logic [4:0]  shots_left;

   logic hit_q;
   logic miss_q;
   logic repeat_q;
   logic invalid_q;

   logic [CNT_W-1:0] blink_cnt;
   logic             blink_phase;

   logic do_clear_all;
   logic do_clear_game;
   logic do_latch;
   logic shot_fire;

   function automatic logic [5:0] popcount35(input logic [34:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 35; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

   assign col_in_flat = {bus.col5_in, bus.col4_in, bus.col3_in, bus.col2_in, bus.col1_in};
   assign in_cells    = popcount35(col_in_flat);

   always_ff @(posedge clk) begin
      if (reset) begin
         save_sync <= '0;
         atk_sync  <= '0;
         save_prev <= 1'b0;
         atk_prev  <= 1'b0;
      end else begin
         save_sync <= {save_sync[0], bus.save_game};
         atk_sync  <= {atk_sync[0], bus.attack_button};
         save_prev <= save_sync[1];
         atk_prev  <= atk_sync[1];
      end
   end

   assign save_rise = save_sync[1] & ~save_prev;
   assign atk_rise  = atk_sync[1] & ~atk_prev;

   assign target_invalid = (bus.columns_attack > 3'd4) || (bus.rows_attack > 3'd6);
   assign target_idx     = ({3'b000, bus.columns_attack} * 6'd7) + {3'b000, bus.rows_attack};
   assign target_mask    = 35'd1 << target_idx;
   assign already_shot   = |(shot_map & target_mask);
   assign is_ship        = |(board & target_mask);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= OFF;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      do_clear_all  = 1'b0;
      do_clear_game = 1'b0;
      do_latch      = 1'b0;
      shot_fire     = 1'b0;
      if (!bus.onOff) begin
         next_state   = OFF;
         do_clear_all = 1'b1;
      end else begin
         case (state)
            OFF: next_state = PLACE;
            PLACE: begin
               // An empty board is never armed: it could never be won.
               if (save_rise && (in_cells != 6'd0)) begin
                  do_latch   = 1'b1;
                  next_state = ARMED;
               end
            end
            ARMED: begin
               if (save_rise && (in_cells != 6'd0)) begin
                  do_latch = 1'b1;
               end
               if (bus.status) begin
                  next_state = ATTACK;
               end
            end
            ATTACK: begin
               if (!bus.status) begin
                  next_state    = PLACE;
                  do_clear_game = 1'b1;
               end else if (hits == ship_cells) begin
                  next_state = WIN;
               end else if (shots_left == 5'd0) begin
                  next_state = LOSE;
               end else begin
                  shot_fire = atk_rise;
               end
            end
            WIN, LOSE: begin
               if (!bus.status) begin
                  next_state    = PLACE;
                  do_clear_game = 1'b1;
               end
            end
            default: begin
               next_state   = OFF;
               do_clear_all = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         board      <= '0;
         shot_map   <= '0;
         ship_cells <= '0;
         hits       <= '0;
         shots_left <= '0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         repeat_q   <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         repeat_q  <= 1'b0;
         invalid_q <= 1'b0;
         if (do_clear_all || do_clear_game) begin
            board      <= '0;
            shot_map   <= '0;
            ship_cells <= '0;
            hits       <= '0;
            if (do_clear_all) begin
               shots_left <= '0;
            end
         end else if (do_latch) begin
            board      <= col_in_flat;
            ship_cells <= in_cells;
            shots_left <= 5'(MAX_SHOTS);
         end else if (shot_fire) begin
            if (target_invalid) begin
               invalid_q <= 1'b1;
            end else if (already_shot) begin
               repeat_q <= 1'b1;
            end else begin
               shot_map <= shot_map | target_mask;
               if (shots_left != 5'd0) begin
                  shots_left <= shots_left - 5'd1;
               end
               if (is_ship) begin
                  hit_q <= 1'b1;
                  hits  <= hits + 6'd1;
               end else begin
                  miss_q <= 1'b1;
               end
            end
         end
      end
   end

   // Placement preview is blanked while status asks for attack without a saved board.
   always_ff @(posedge clk) begin
      if (reset) begin
         place_q <= '0;
      end else begin
         place_q <= bus.status ? '0 : col_in_flat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || (state != ATTACK)) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      display = '0;
      case (state)
         PLACE:   display = place_q;
         ARMED:   display = board;
         ATTACK:  display = (shot_map & board) | (blink_phase ? (shot_map & ~board) : '0);
         WIN:     display = '1;
         // Hits are a subset of the board, so the reveal already lights them.
         LOSE:    display = board;
         default: display = '0;
      endcase
   end

   assign bus.col1_out     = display[6:0];
   assign bus.col2_out     = display[13:7];
   assign bus.col3_out     = display[20:14];
   assign bus.col4_out     = display[27:21];
   assign bus.col5_out     = display[34:28];
   assign bus.hit          = hit_q;
   assign bus.miss         = miss_q;
   assign bus.repeat_shot  = repeat_q;
   assign bus.invalid_shot = invalid_q;
   assign bus.win          = (state == WIN);
   assign bus.game_over    = (state == LOSE);
   assign bus.shots_left   = shots_left;
   assign bus.fsm_state    = state;
endmodule

// File: doc/attack_controller.md
Name: attack_controller

Overview:
Clocked game sequencer for the 5x7 LED battleship board. It runs the placement phase, latches the placed fleet on save_game, and processes attack shots from the coordinate switches and attack_button. It keeps the shot map, hit count and shot budget, and detects win or loss. It drives the five matrix column outputs for each game state. It replaces the combinational show-mux as the owner of col1_out..col5_out.

Parameters:
MAX_SHOTS, 15, shots allowed per game (1..31).
BLINK_DIV, 25000000, clk cycles per half-period of the miss-blink phase.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clears all state
onOff  input  1  game power switch; 0 forces OFF
status  input  1  0 = placement, 1 = attack
save_game  input  1  latches placement board (level input, edge-detected)
attack_button  input  1  fires a shot (debounced level, edge-detected)
col1_in..col5_in  input  7 each  placement board; bit r = row r
columns_attack  input  3  target column, 0..4 valid (0 = col1)
rows_attack  input  3  target row, 0..6 valid
col1_out..col5_out  output  7 each  matrix column drive
hit, miss, repeat_shot, invalid_shot  output  1 each  one-cycle result pulses
win, game_over  output  1 each  level flags
shots_left  output  5  remaining shots

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state OFF; all outputs 0; board, shot map, hits and blink counter cleared; shots_left = 0.
- Input synchronisation: save_game and attack_button each pass through 2 sync flops, then a rising-edge detector. Each input rise produces a one-cycle internal rise, 2 cycles later.
- State machine: OFF, PLACE, ARMED, ATTACK, WIN, LOSE.
  - OFF: outputs all 0. Goes to PLACE when onOff = 1.
  - Any state with onOff = 0: go to OFF next cycle, clearing board, shot map, hits and shots_left.
  - PLACE: col*_out mirror col*_in registered (1-cycle latency).
    - On save_game rise: latch board, and set ship_cells = popcount of the 35 bits, shots_left = MAX_SHOTS.
    - If ship_cells = 0, ignore and stay in PLACE. Otherwise go to ARMED.
  - ARMED: col*_out show the latched board. status = 1 goes to ATTACK. save_game rise re-latches the board.
  - status = 1 while in PLACE without a saved board: stay in PLACE, col*_out = 0.
  - ATTACK: display shows hit cells steady-on and miss cells lit only while blink_phase = 1. Unshot cells are off; the board is never shown.
  - On attack_button rise in ATTACK, the result pulse occurs in the next cycle:
    - columns_attack > 4 or rows_attack > 6: invalid_shot pulse; nothing else changes.
    - Cell already shot: repeat_shot pulse; no shot consumed.
    - Otherwise: mark the cell shot and decrement shots_left. If the board bit is 1, pulse hit and increment hits; else pulse miss.
  - End-of-game checks, evaluated in the cycle of the pulse (new values):
    - hits = ship_cells: go to WIN. Win has priority over shots_left = 0 on the same shot.
    - Else shots_left = 0: go to LOSE.
  - WIN: win = 1; all columns = 7'b1111111.
  - LOSE: game_over = 1; display shows the board (reveal) OR the hits.
  - WIN/LOSE with status = 0: go to PLACE with board, shot map and hits cleared. Same applies to ATTACK with status = 0 (abandon game).
- Blink counter: free-running 0..BLINK_DIV-1 and reset when not in ATTACK. blink_phase toggles on wrap.
- Counter widths: hits and ship_cells are 6 bits; shots_left is 5 bits and never decrements below 0.
- Only one shot is processed per button rise. Button rises while not in ATTACK are dropped.

Test Plan:
- Reset and power-on: assert reset 2 cycles with onOff = 1 -> all outputs 0 and state OFF. Release reset -> PLACE; col1_in = 7'b0000011 appears on col1_out 1 cycle later.
- Empty board: save_game with all col_in = 0 -> stays in PLACE, shots_left = 0. Then col3_in = 7'b0000100 plus save_game -> ARMED, shots_left = 15.
- Single ship cell (col3, row 2): status = 1, fire (0,0) -> miss pulse, shots_left = 14. Fire (2,2) -> hit pulse, win = 1, all columns 7'h7F.
- Invalid and repeat shots: fire (5,0) -> invalid_shot, shots_left unchanged. Fire (0,7) -> invalid_shot. Fire (0,0) twice -> miss then repeat_shot, shots_left drops by 1 only.
- Shot budget: MAX_SHOTS = 2 with 2 ship cells, fire 2 misses -> game_over = 1 and board revealed. Variant: hit the last ship cell on the final shot -> win = 1, game_over = 0.
- Mid-game abort: onOff to 0 during ATTACK -> OFF next cycle, outputs 0. Separately, status to 0 in LOSE -> PLACE with shot map cleared. Synchronous reset mid-shot (same cycle as button rise) -> no pulse, state OFF.
